// File: rtl/gecko_decode_scoreboard.sv
// gecko_decode_scoreboard: per-register pending-write scoreboard for the decode stage.
// Tracks in-flight writes with saturating counters, holds the execute-forwarding
// register and produces per-operand readiness plus a single issue-ready signal.
// Optional feature macro: GECKO_SCOREBOARD_FORWARD_EN (lets exec_saved satisfy readiness).
module gecko_decode_scoreboard #(
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned COUNTER_WIDTH = 2,
  parameter int unsigned NUM_WB_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH    = $clog2(NUM_REGS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 issue_valid,
  output logic                                 issue_ready,
  input  logic [ADDR_WIDTH-1:0]                issue_rs1,
  input  logic [ADDR_WIDTH-1:0]                issue_rs2,
  input  logic [ADDR_WIDTH-1:0]                issue_rd,
  input  logic                                 issue_rs1_used,
  input  logic                                 issue_rs2_used,
  input  logic                                 issue_rd_used,
  input  logic                                 issue_exec_result,
  output logic                                 rs1_valid,
  output logic                                 rs2_valid,
  output logic                                 rd_valid,
  input  logic [NUM_WB_PORTS-1:0]              wb_valid,
  input  logic [NUM_WB_PORTS*ADDR_WIDTH-1:0]   wb_addr,
  input  logic                                 flush_exec_saved,
  output logic [ADDR_WIDTH-1:0]                exec_saved,
  output logic                                 busy,
  output logic                                 error
);

`ifdef GECKO_SCOREBOARD_FORWARD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  // Counter array covers the full address space; slot 0 and slots past NUM_REGS stay 0.
  localparam int unsigned NumSlots = 2 ** ADDR_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] CntMax = '1;

  logic [COUNTER_WIDTH-1:0] r_counter   [NumSlots];
  logic [COUNTER_WIDTH-1:0] w_counter_d [NumSlots];
  logic [ADDR_WIDTH-1:0]    r_exec_saved, w_exec_saved_d;
  logic                     r_error, w_error_d;

  logic                     w_fire;
  logic                     w_inc;
  logic [COUNTER_WIDTH+1:0] w_dec;
  logic [COUNTER_WIDTH+1:0] w_sum;

  // Operand readiness from registered state only; no bypass from writeback.
  always_comb begin
    rs1_valid = !issue_rs1_used || (issue_rs1 == '0) || (r_counter[issue_rs1] == '0) ||
                (FwdEn && (issue_rs1 == r_exec_saved) && (r_exec_saved != '0));
    rs2_valid = !issue_rs2_used || (issue_rs2 == '0) || (r_counter[issue_rs2] == '0) ||
                (FwdEn && (issue_rs2 == r_exec_saved) && (r_exec_saved != '0));
    rd_valid  = !issue_rd_used || (issue_rd == '0) || (r_counter[issue_rd] != CntMax);
    issue_ready = rs1_valid && rs2_valid && rd_valid;
    w_fire      = issue_valid && issue_ready;
  end

  // Counter next-state: add issue, subtract each matching writeback port, then saturate.
  // The sum is kept two bits wider so its MSB flags an underflow.
  always_comb begin
    w_error_d = r_error;
    w_inc     = 1'b0;
    w_dec     = '0;
    w_sum     = '0;
    for (int unsigned r = 0; r < NumSlots; r++) begin
      w_counter_d[r] = '0;
      if (r != 0 && r < NUM_REGS) begin
        w_inc = w_fire && issue_rd_used && (issue_rd == ADDR_WIDTH'(r));
        w_dec = '0;
        for (int unsigned p = 0; p < NUM_WB_PORTS; p++) begin
          if (wb_valid[p] && (wb_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))) begin
            w_dec = w_dec + (COUNTER_WIDTH+2)'(1);
          end
        end
        w_sum = {2'b00, r_counter[r]} + (COUNTER_WIDTH+2)'(w_inc) - w_dec;
        if (w_sum[COUNTER_WIDTH+1]) begin
          w_counter_d[r] = '0;
          w_error_d      = 1'b1;
        end else if (w_sum[COUNTER_WIDTH]) begin
          w_counter_d[r] = CntMax;
          w_error_d      = 1'b1;
        end else begin
          w_counter_d[r] = w_sum[COUNTER_WIDTH-1:0];
        end
      end
    end
  end

  // Forwarding register: flush wins, ALU result captures rd, a load/CSR to it supersedes it.
  always_comb begin
    w_exec_saved_d = r_exec_saved;
    if (flush_exec_saved) begin
      w_exec_saved_d = '0;
    end else if (w_fire && issue_rd_used && issue_exec_result) begin
      w_exec_saved_d = issue_rd;
    end else if (w_fire && issue_rd_used && !issue_exec_result &&
                 (issue_rd == r_exec_saved)) begin
      w_exec_saved_d = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NumSlots; r++) begin
        r_counter[r] <= '0;
      end
      r_exec_saved <= '0;
      r_error      <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NumSlots; r++) begin
        r_counter[r] <= w_counter_d[r];
      end
      r_exec_saved <= w_exec_saved_d;
      r_error      <= w_error_d;
    end
  end

  // Status outputs derived from registered state.
  always_comb begin
    busy = 1'b0;
    for (int unsigned r = 0; r < NumSlots; r++) begin
      busy = busy || (r_counter[r] != '0);
    end
    exec_saved = r_exec_saved;
    error      = r_error;
  end

endmodule
